shift_add_multiplier: RTL and testbench



---
 rtl/shift_add_multiplier.sv | 132 +++++++++++++
 tb/tb_shift_add_multiplier.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/shift_add_multiplier.sv
// Sequential 16x16 unsigned shift-and-add multiplier (MUL execution unit) and the
// 16-bit carry-lookahead adder it uses for each partial-product step.

module cla_adder16 (
  input  logic [15:0] x,
  input  logic [15:0] y,
  input  logic        carry_in,
  output logic [15:0] sum,
  output logic        carry_out
);
  logic [15:0] g, p, c;
  logic [3:0]  gg, gp;
  logic [4:0]  gc;

  assign g = x & y;
  assign p = x ^ y;

  // Two-level lookahead: 4-bit groups, then carries across the groups.
  for (genvar i = 0; i < 4; i++) begin : g_grp
    localparam int B = 4 * i;
    assign c[B]   = gc[i];
    assign c[B+1] = g[B] | (p[B] & gc[i]);
    assign c[B+2] = g[B+1] | (p[B+1] & g[B]) | (p[B+1] & p[B] & gc[i]);
    assign c[B+3] = g[B+2] | (p[B+2] & g[B+1]) | (p[B+2] & p[B+1] & g[B])
                  | ((&p[B+2:B]) & gc[i]);
    assign gg[i]  = g[B+3] | (p[B+3] & g[B+2]) | (p[B+3] & p[B+2] & g[B+1])
                  | ((&p[B+3:B+1]) & g[B]);
    assign gp[i]  = &p[B+3:B];
  end

  assign gc[0] = carry_in;
  assign gc[1] = gg[0] | (gp[0] & gc[0]);
  assign gc[2] = gg[1] | (gp[1] & gg[0]) | ((&gp[1:0]) & gc[0]);
  assign gc[3] = gg[2] | (gp[2] & gg[1]) | ((&gp[2:1]) & gg[0]) | ((&gp[2:0]) & gc[0]);
  assign gc[4] = gg[3] | (gp[3] & gg[2]) | ((&gp[3:2]) & gg[1]) | ((&gp[3:1]) & gg[0])
               | ((&gp[3:0]) & gc[0]);

  assign sum       = p ^ c;
  assign carry_out = gc[4];
endmodule

// state | meaning
// IDLE  | waiting for start; operands captured when it arrives
// RUN   | one add-and-shift iteration per clock, 16 in total
// DONE  | one-cycle done pulse; product/ovf freshly updated
module shift_add_multiplier #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product,
  output logic               ovf
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state, state_nx;
  logic [WIDTH-1:0]   hi, lo, mcand;
  logic [CNT_W-1:0]   count;
  logic [WIDTH-1:0]   add_y, add_sum;
  logic               add_cout;
  logic [2*WIDTH-1:0] shift_nx;
  logic               last_iter;

  assign add_y = lo[0] ? mcand : '0;

  cla_adder16 u_adder (
    .x         (hi),
    .y         (add_y),
    .carry_in  (1'b0),
    .sum       (add_sum),
    .carry_out (add_cout)
  );

  // The adder carry becomes the new top bit, so no partial-sum bit is ever lost.
  assign shift_nx  = {add_cout, add_sum, lo[WIDTH-1:1]};
  assign last_iter = (count == CNT_W'(WIDTH - 1));

  assign busy = (state == RUN);
  assign done = (state == DONE);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = RUN;
      RUN:     if (last_iter) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hi      <= '0;
      lo      <= '0;
      mcand   <= '0;
      count   <= '0;
      product <= '0;
      ovf     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            mcand <= a;
            lo    <= b;
            hi    <= '0;
            count <= '0;
          end
        end
        RUN: begin
          {hi, lo} <= shift_nx;
          count    <= count + CNT_W'(1);
          if (last_iter) begin
            product <= shift_nx;
            ovf     <= |shift_nx[2*WIDTH-1:WIDTH];
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_shift_add_multiplier.sv
// Directed bench for shift_add_multiplier: latency, handshake, carry path,
// ignored starts, reset abort and back-to-back operation.

module tb_shift_add_multiplier;
  logic        clk = 1'b0;
  logic        rst, start;
  logic [15:0] a, b;
  logic        busy, done, ovf;
  logic [31:0] product;

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  shift_add_multiplier dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .product (product),
    .ovf     (ovf)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  // Pulse start for one cycle, scramble the inputs afterwards, and time the result.
  task automatic run_mul(input string tag, input logic [15:0] ta, input logic [15:0] tb,
                         input logic [31:0] ep, input logic eo);
    int lat, nbusy;
    @(negedge clk); a = ta; b = tb; start = 1'b1;
    @(negedge clk); start = 1'b0; a = ~ta; b = ~tb;
    lat = 0; nbusy = 0;
    for (int n = 1; n <= 40; n++) begin
      if (n > 1) @(negedge clk);
      if (busy) nbusy++;
      if (done) begin
        lat = n;
        break;
      end
    end
    check({tag, " latency"}, 32'(lat), 32'd17);
    check({tag, " busy_cycles"}, 32'(nbusy), 32'd16);
    check({tag, " product"}, product, ep);
    check({tag, " ovf"}, {31'b0, ovf}, {31'b0, eo});
    @(negedge clk);
    check({tag, " done_pulse"}, {30'b0, done, busy}, 32'd0);
  endtask

  typedef struct { logic [15:0] a; logic [15:0] b; logic [31:0] p; logic o; } vec_t;
  vec_t tab[10];

  initial begin
    int ndone, last_cyc, got;
    logic [31:0] seen_p;
    logic scrambled;

    tab[0] = '{16'hFFFF, 16'hFFFF, 32'hFFFE0001, 1'b1};
    tab[1] = '{16'h8000, 16'h0002, 32'h00010000, 1'b1};
    tab[2] = '{16'h0000, 16'h1234, 32'h00000000, 1'b0};
    tab[3] = '{16'h1234, 16'h0001, 32'h00001234, 1'b0};
    tab[4] = '{16'h00FF, 16'h0100, 32'h0000FF00, 1'b0};
    tab[5] = '{16'h0100, 16'h0100, 32'h00010000, 1'b1};
    tab[6] = '{16'h1234, 16'h5678, 32'h06260060, 1'b1};
    tab[7] = '{16'hABCD, 16'h0003, 32'h00020367, 1'b1};
    tab[8] = '{16'h00FF, 16'h00FF, 32'h0000FE01, 1'b0};
    tab[9] = '{16'hFFFF, 16'h0001, 32'h0000FFFF, 1'b0};

    rst = 1'b1; start = 1'b1; a = 16'h1111; b = 16'h2222;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset outputs", {product[31:3], ovf, done, busy}, 32'd0);
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    check("idle without start", {30'b0, done, busy}, 32'd0);

    run_mul("5x6", 16'd5, 16'd6, 32'h0000001E, 1'b0);
    run_mul("ffff_sq", 16'hFFFF, 16'hFFFF, 32'hFFFE0001, 1'b1);
    run_mul("8000x2", 16'h8000, 16'h0002, 32'h00010000, 1'b1);
    run_mul("zero", 16'h0000, 16'h1234, 32'h00000000, 1'b0);
    run_mul("identity", 16'h1234, 16'h0001, 32'h00001234, 1'b0);

    // start raised at the 5th RUN cycle must be dropped
    @(negedge clk); a = 16'd3; b = 16'd4; start = 1'b1;
    @(negedge clk); start = 1'b0;
    ndone = 0; seen_p = '0;
    for (int n = 2; n <= 60; n++) begin
      @(negedge clk);
      if (done) begin
        ndone++;
        seen_p = product;
      end
      if (n == 5) begin start = 1'b1; a = 16'd7; b = 16'd7; end
      if (n == 6) start = 1'b0;
    end
    check("ignored start done_count", 32'(ndone), 32'd1);
    check("ignored start product", seen_p, 32'h0000000C);

    // reset in the 8th RUN cycle aborts silently
    run_mul("2x3", 16'd2, 16'd3, 32'h00000006, 1'b0);
    @(negedge clk); a = 16'h00FF; b = 16'h0100; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (7) @(negedge clk);
    check("pre-abort busy", {31'b0, busy}, 32'd1);
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    check("abort outputs", {product[31:3], ovf, done, busy}, 32'd0);
    ndone = 0;
    repeat (25) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("abort no done", 32'(ndone), 32'd0);
    check("abort product held", product, 32'd0);
    run_mul("after abort", 16'h00FF, 16'h0100, 32'h0000FF00, 1'b0);

    // start held high: one result every 18 cycles
    @(negedge clk); a = tab[0].a; b = tab[0].b; start = 1'b1;
    last_cyc = 0;
    for (int i = 0; i < 10; i++) begin
      got = 0; scrambled = 1'b0;
      for (int n = 0; n < 40; n++) begin
        @(negedge clk);
        if (busy && !scrambled) begin
          a = 16'hDEAD; b = 16'hBEEF; scrambled = 1'b1;
        end
        if (done) begin
          got = 1;
          break;
        end
      end
      check($sformatf("b2b[%0d] done_seen", i), 32'(got), 32'd1);
      check($sformatf("b2b[%0d] product", i), product, tab[i].p);
      check($sformatf("b2b[%0d] ovf", i), {31'b0, ovf}, {31'b0, tab[i].o});
      if (i > 0) check($sformatf("b2b[%0d] interval", i), 32'(cyc - last_cyc), 32'd18);
      last_cyc = cyc;
      if (i < 9) begin
        a = tab[i+1].a; b = tab[i+1].b;
      end else begin
        start = 1'b0;
      end
    end
    repeat (3) @(negedge clk);
    check("final idle", {30'b0, done, busy}, 32'd0);
    check("final product held", product, 32'h0000FFFF);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
